// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad geometry, types and key-code helper
package keypad_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    typedef logic [3:0]  key_code_t;
    typedef logic [15:0] key_map_t;
    function automatic key_code_t key_index(input key_map_t m);
        key_index = '0;
        for (int i = 0; i < 16; i++)
            if (m[i]) key_index = 4'(i);
    endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus key-entry outputs
interface keypad_scanner_if;
    import keypad_pkg::*;
    logic [NUM_COLS-1:0] col_in;
    logic [NUM_ROWS-1:0] row_out;
    logic                key_valid_out;
    key_code_t           key_code_out;
    logic [31:0]         val_out;
    modport master(input col_in, output row_out, key_valid_out, key_code_out, val_out);
    modport slave(output col_in, input row_out, key_valid_out, key_code_out, val_out);
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a key map once it repeats for DEBOUNCE_SCANS frames
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     frame_i,
    input  key_map_t snap_i,
    output key_map_t map_o,
    output logic     upd_o
);
    key_map_t  cand_q, cand_d, deb_q;
    logic [3:0] st_q, st_d;
    always_comb begin
        cand_d = frame_i ? snap_i : cand_q;
        st_d   = !frame_i ? st_q : (snap_i != cand_q) ? 4'd1 : (st_q == 4'd15) ? st_q : st_q + 4'd1;
        upd_o  = frame_i && (st_d == 4'(DEBOUNCE_SCANS));
        map_o  = upd_o ? cand_d : deb_q;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cand_q <= '0;
            st_q   <= '0;
            deb_q  <= '0;
        end else begin
            cand_q <= cand_d;
            st_q   <= st_d;
            deb_q  <= map_o;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 keypad, debounces frames, emits codes into a hex accumulator
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_COUNT     = 100_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic              clk_in,
    input logic              rst_in,
    keypad_scanner_if.master kp
);
    localparam int CW = $clog2(SCAN_COUNT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    row_q, row_d, sync1_q, sync2_q;
    logic [1:0]    row_idx;
    key_map_t      snap_q, snap_d, map;
    key_code_t     code_q, code_d, idx;
    logic [31:0]   val_q, val_d;
    logic          sample, frame, upd, press, valid_q, armed_q, armed_d;
    keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .frame_i(frame),
        .snap_i (snap_d),
        .map_o  (map),
        .upd_o  (upd)
    );
    always_comb begin
        sample  = cnt_q == CW'(SCAN_COUNT);
        frame   = sample && row_q == 4'b0111;
        cnt_d   = sample ? '0 : cnt_q + CW'(1);
        row_d   = sample ? {row_q[2:0], row_q[3]} : row_q;
        row_idx = !row_q[1] ? 2'd1 : !row_q[2] ? 2'd2 : !row_q[3] ? 2'd3 : 2'd0;
        snap_d  = snap_q;
        if (sample) snap_d[{row_idx, 2'b00} +: 4] = ~sync2_q;
        // armed blocks repeats until the keypad has been seen fully released
        idx     = key_index(map);
        press   = upd && $onehot(map) && armed_q;
        armed_d = press ? 1'b0 : (upd && map == '0) ? 1'b1 : armed_q;
        code_d  = press ? idx : code_q;
        val_d   = press ? {val_q[27:0], idx} : val_q;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q   <= '0;
            row_q   <= 4'b1110;
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            snap_q  <= '0;
            valid_q <= 1'b0;
            armed_q <= 1'b1;
            code_q  <= '0;
            val_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            sync1_q <= kp.col_in;
            sync2_q <= sync1_q;
            snap_q  <= snap_d;
            valid_q <= press;
            armed_q <= armed_d;
            code_q  <= code_d;
            val_q   <= val_d;
        end
    end
    assign kp.row_out       = row_q;
    assign kp.key_valid_out = valid_q;
    assign kp.key_code_out  = code_q;
    assign kp.val_out       = val_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios with a matrix model driving the columns
module tb_keypad_scanner;
    import keypad_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = '0;
    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    int          p0;
    keypad_scanner_if kp();
    keypad_scanner #(.SCAN_COUNT(3), .DEBOUNCE_SCANS(2)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .kp    (kp)
    );
    always #5 clk = ~clk;
    always_comb begin
        kp.col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && !kp.row_out[r]) kp.col_in[c] = 1'b0;
    end
    always @(posedge clk) if (kp.key_valid_out) pulses++;
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    initial begin
        do_reset();
        chk("rst_row", 32'(kp.row_out), 32'hE);
        chk("rst_valid", 32'(kp.key_valid_out), 0);
        chk("rst_code", 32'(kp.key_code_out), 0);
        chk("rst_val", kp.val_out, 0);
        p0 = pulses;
        cyc(4);
        chk("row_rot1", 32'(kp.row_out), 32'hD);
        cyc(12);
        chk("row_wrap", 32'(kp.row_out), 32'hE);
        cyc(192);
        chk("idle_pulses", 32'(pulses - p0), 0);
        chk("idle_val", kp.val_out, 0);
        // single key 9 held from frame start
        p0 = pulses;
        keys = 16'(1) << 9;
        cyc(31);
        chk("k9_early", 32'(kp.key_valid_out), 0);
        cyc(1);
        chk("k9_valid", 32'(kp.key_valid_out), 1);
        chk("k9_code", 32'(kp.key_code_out), 32'h9);
        chk("k9_val", kp.val_out, 32'h9);
        cyc(48);
        chk("k9_once", 32'(pulses - p0), 1);
        keys = '0;
        cyc(48);
        // one-frame glitch
        p0 = pulses;
        keys = 16'(1) << 6;
        cyc(16);
        keys = '0;
        cyc(48);
        chk("glitch_pulses", 32'(pulses - p0), 0);
        chk("glitch_val", kp.val_out, 32'h9);
        // two keys together, then key 5
        p0 = pulses;
        keys = (16'(1) << 3) | (16'(1) << 10);
        cyc(64);
        chk("multi_pulses", 32'(pulses - p0), 0);
        keys = '0;
        cyc(48);
        keys = 16'(1) << 5;
        cyc(48);
        chk("k5_pulses", 32'(pulses - p0), 1);
        chk("k5_code", 32'(kp.key_code_out), 32'h5);
        chk("k5_val", kp.val_out, 32'h95);
        keys = '0;
        cyc(48);
        // digit entry 1..9 from reset
        do_reset();
        chk("seq_rst_val", kp.val_out, 0);
        p0 = pulses;
        for (int k = 1; k <= 9; k++) begin
            keys = 16'(1) << k;
            cyc(48);
            chk("seq_code", 32'(kp.key_code_out), 32'(k));
            keys = '0;
            cyc(48);
        end
        chk("seq_pulses", 32'(pulses - p0), 9);
        chk("seq_val", kp.val_out, 32'h2345_6789);
        // key C held across a mid-frame reset
        keys = 16'(1) << 12;
        cyc(48);
        chk("kc_val", kp.val_out, 32'h3456_789C);
        cyc(8);
        do_reset();
        chk("mid_rst_val", kp.val_out, 0);
        chk("mid_rst_row", 32'(kp.row_out), 32'hE);
        p0 = pulses;
        cyc(31);
        chk("kc_early", 32'(kp.key_valid_out), 0);
        cyc(1);
        chk("kc_valid", 32'(kp.key_valid_out), 1);
        chk("kc_code", 32'(kp.key_code_out), 32'hC);
        chk("kc_val2", kp.val_out, 32'hC);
        cyc(16);
        keys = '0;
        cyc(48);
        keys = 16'(1) << 12;
        cyc(48);
        chk("kc_pulses", 32'(pulses - p0), 2);
        chk("kc_val3", kp.val_out, 32'hCC);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
